// File: rtl/dmul_pkg.sv
// Shared types and constants for the dmul_engine multiply engine.
// The DMUL_FAST_MUL_EN macro (see booth_mul16) selects the multiplier build.
package dmul_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MUL  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int BYTES_PER_OPND = 2;
  localparam int BYTES_PER_PROD = 4;
  localparam int MUL_LAT        = 16;

  typedef logic signed [31:0] product_t;

  // One radix-2 Booth iteration: add/subtract the multiplicand, then
  // arithmetic-shift {acc, q, q1} right by one.
  function automatic logic [33:0] booth_step(input logic signed [16:0] acc,
                                             input logic [15:0]        q,
                                             input logic               q1,
                                             input logic signed [16:0] m);
    logic signed [16:0] sum;
    case ({q[0], q1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    return {sum[16], sum, q};
  endfunction

endpackage

// File: rtl/dmul_engine_booth_mul16.sv
// Signed 16x16 -> 32 multiplier; DMUL_FAST_MUL_EN selects a single-cycle product,
// otherwise a 16-iteration radix-2 Booth sequencer with a 17-bit accumulator.
module booth_mul16
  import dmul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        done,
  output product_t    p
);

`ifdef DMUL_FAST_MUL_EN
  logic     done_r;
  product_t p_r;

  // Product registered on go; done follows one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_r <= 1'b0;
      p_r    <= '0;
    end else begin
      done_r <= go;
      if (go) begin
        p_r <= $signed(a) * $signed(b);
      end else begin
        p_r <= p_r;
      end
    end
  end

  assign done = done_r;
  assign p    = p_r;
`else
  logic signed [16:0] acc_r;
  logic signed [16:0] m_r;
  logic [15:0]        q_r;
  logic               q1_r;
  logic [4:0]         cnt_r;
  logic               run_r;

  // The first iteration is applied at load, so MUL_LAT iterations are
  // complete in the cycle where cnt_r reaches MUL_LAT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= '0;
      m_r   <= '0;
      q_r   <= '0;
      q1_r  <= 1'b0;
      cnt_r <= '0;
      run_r <= 1'b0;
    end else if (go) begin
      {acc_r, q_r, q1_r} <= booth_step(17'sd0, a, 1'b0, {b[15], b});
      m_r   <= {b[15], b};
      cnt_r <= 5'd1;
      run_r <= 1'b1;
    end else if (run_r && (cnt_r != 5'(MUL_LAT))) begin
      {acc_r, q_r, q1_r} <= booth_step(acc_r, q_r, q1_r, m_r);
      cnt_r <= cnt_r + 5'd1;
      run_r <= 1'b1;
    end else begin
      run_r <= 1'b0;
    end
  end

  assign done = run_r && (cnt_r == 5'(MUL_LAT));
  assign p    = {acc_r[15:0], q_r};
`endif

endmodule

// File: rtl/dmul_engine.sv
// Program-3 multiply engine: reads operand pairs from byte memory, writes signed
// products back big-endian. Multiplier build chosen by DMUL_FAST_MUL_EN.
module dmul_engine
  import dmul_pkg::*;
#(
  parameter int NUM_PAIRS = 16,
  parameter int SRC_BASE  = 0,
  parameter int DST_BASE  = 64,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        mem_wdata,
  output logic              mem_we
);

  localparam int PAIR_W = $clog2(NUM_PAIRS);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_PROD - 1);

  state_t                      state_r, next_state_s;
  logic                        armed_r;
  logic [PAIR_W-1:0]           pair_r;
  logic [1:0]                  byte_idx_r;
  logic [8*BYTES_PER_OPND-1:0] a_r;
  logic [7:0]                  b_hi_r;
  product_t                    p_r;
  logic                        last_pair_s;
  logic                        mul_go_s;
  logic                        mul_done_s;
  product_t                    mul_p_s;

  assign last_pair_s = (pair_r == PAIR_W'(NUM_PAIRS - 1));
  assign mul_go_s    = (state_r == RD) && (byte_idx_r == LAST_BYTE) && !start;

  booth_mul16 u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (mul_go_s),
    .a     (a_r),
    .b     ({b_hi_r, mem_rdata}),
    .done  (mul_done_s),
    .p     (mul_p_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state; start seen high during a run aborts back to IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (armed_r && !start) next_state_s = RD;
        else                   next_state_s = IDLE;
      end
      RD: begin
        if (start)                          next_state_s = IDLE;
        else if (byte_idx_r == LAST_BYTE)   next_state_s = MUL;
        else                                next_state_s = RD;
      end
      MUL: begin
        if (start)           next_state_s = IDLE;
        else if (mul_done_s) next_state_s = WR;
        else                 next_state_s = MUL;
      end
      WR: begin
        if (start)                          next_state_s = IDLE;
        else if (byte_idx_r != LAST_BYTE)   next_state_s = WR;
        else if (last_pair_s)               next_state_s = DONE;
        else                                next_state_s = RD;
      end
      DONE: begin
        if (start) next_state_s = IDLE;
        else       next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Arm flag, byte/pair counters, operand capture and product register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed_r    <= 1'b0;
      pair_r     <= '0;
      byte_idx_r <= '0;
      a_r        <= '0;
      b_hi_r     <= '0;
      p_r        <= '0;
    end else begin
      if (start)                                     armed_r <= 1'b1;
      else if (state_r == IDLE && next_state_s == RD) armed_r <= 1'b0;
      else                                           armed_r <= armed_r;

      case (state_r)
        RD: begin
          byte_idx_r <= byte_idx_r + 2'd1;
          case (byte_idx_r)
            2'd0:    a_r[15:8] <= mem_rdata;
            2'd1:    a_r[7:0]  <= mem_rdata;
            2'd2:    b_hi_r    <= mem_rdata;
            default: b_hi_r    <= b_hi_r;
          endcase
        end
        MUL: begin
          byte_idx_r <= '0;
          if (mul_done_s) p_r <= mul_p_s;
          else            p_r <= p_r;
        end
        WR: begin
          byte_idx_r <= byte_idx_r + 2'd1;
          if (byte_idx_r == LAST_BYTE && !last_pair_s) pair_r <= pair_r + 1'b1;
          else                                         pair_r <= pair_r;
        end
        DONE: begin
          pair_r     <= pair_r;
          byte_idx_r <= byte_idx_r;
        end
        default: begin
          pair_r     <= '0;
          byte_idx_r <= '0;
        end
      endcase
    end
  end

  // Memory-port and handshake outputs decoded from the current state.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    case (state_r)
      RD: begin
        busy     = 1'b1;
        mem_addr = ADDR_W'(SRC_BASE) + ADDR_W'({pair_r, byte_idx_r});
      end
      MUL: begin
        busy = 1'b1;
      end
      WR: begin
        busy     = 1'b1;
        mem_addr = ADDR_W'(DST_BASE) + ADDR_W'({pair_r, byte_idx_r});
        mem_we   = !start && rst_n;
        case (byte_idx_r)
          2'd0:    mem_wdata = p_r[31:24];
          2'd1:    mem_wdata = p_r[23:16];
          2'd2:    mem_wdata = p_r[15:8];
          default: mem_wdata = p_r[7:0];
        endcase
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmul_engine.sv
// Self-checking bench for dmul_engine: byte memory model plus a B*A reference
// computed from the saved source image. Honours DMUL_FAST_MUL_EN for timing.
module tb_dmul_engine;

`ifdef DMUL_FAST_MUL_EN
  localparam int RUN_CYC      = 144;
  localparam int ABORT_CYC    = 20;
  localparam int WR_ABORT_CYC = 6;
  localparam int RST_CYC      = 7;
`else
  localparam int RUN_CYC      = 384;
  localparam int ABORT_CYC    = 50;
  localparam int WR_ABORT_CYC = 21;
  localparam int RST_CYC      = 22;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       done;
  logic       busy;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_wdata;
  logic       mem_we;

  logic [7:0] mem [0:255];
  logic [7:0] src [0:63];
  int n_cmp;
  int n_bad;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  dmul_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .done      (done),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

  // Advance one clock; the memory write port is modelled here.
  task automatic tick();
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    @(negedge clk);
    w = mem_we;
    a = mem_addr;
    d = mem_wdata;
    @(posedge clk);
    if (w === 1'b1) mem[a] = d;
    #1;
  endtask

  function automatic logic [31:0] ref_prod(int j);
    int ia;
    int ib;
    ia = $signed({src[4*j], src[4*j+1]});
    ib = $signed({src[4*j+2], src[4*j+3]});
    return 32'(ib * ia);
  endfunction

  function automatic logic [31:0] got_prod(int j);
    return {mem[64+4*j], mem[65+4*j], mem[66+4*j], mem[67+4*j]};
  endfunction

  task automatic load_random();
    for (int i = 0; i < 64; i++) begin
      src[i] = 8'($urandom);
      mem[i] = src[i];
    end
    for (int i = 64; i < 128; i++) mem[i] = 8'hAA;
  endtask

  task automatic set_pair(int j, int a, int b);
    logic [15:0] ua;
    logic [15:0] ub;
    ua = 16'(a);
    ub = 16'(b);
    src[4*j] = ua[15:8]; src[4*j+1] = ua[7:0];
    src[4*j+2] = ub[15:8]; src[4*j+3] = ub[7:0];
    for (int k = 0; k < 4; k++) mem[4*j+k] = src[4*j+k];
  endtask

  task automatic run_once(output int cyc, output bit to);
    int w;
    w = 0;
    start = 1'b1; tick();
    start = 1'b0; tick();
    while (busy !== 1'b1 && w < 8) begin tick(); w++; end
    cyc = 0;
    while (done !== 1'b1 && cyc < 4000) begin tick(); cyc++; end
    to = (done !== 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({busy, done, mem_we, mem_addr, mem_wdata} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got busy=%b done=%b we=%b addr=%h wdata=%h want all 0",
               busy, done, mem_we, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    repeat (5) tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_no_run got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int cyc;
    bit to;
    logic [31:0] exp4 [4];
    exp4[0] = 32'h0000000F; exp4[1] = 32'hFFFFFFF2;
    exp4[2] = 32'h00000000; exp4[3] = 32'h3FFF0001;
    load_random();
    set_pair(0, 3, 5); set_pair(1, -2, 7); set_pair(2, 0, -1); set_pair(3, 32767, 32767);
    run_once(cyc, to);
    n_cmp++;
    if (to || cyc != RUN_CYC) begin
      n_bad++;
      $display("FAIL basic_latency got %0d (timeout=%0b) want %0d", cyc, to, RUN_CYC);
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done got done=%b busy=%b want 1 0", done, busy);
    end
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if (got_prod(j) !== ((j < 4) ? exp4[j] : ref_prod(j))) begin
        n_bad++;
        $display("FAIL basic_prod[%0d] got %h want %h", j, got_prod(j),
                 (j < 4) ? exp4[j] : ref_prod(j));
      end
    end
  endtask

  task automatic test_corner();
    int cyc;
    bit to;
    load_random();
    set_pair(0, -32768, -32768); set_pair(1, -32768, 1); set_pair(2, 32767, -32768);
    run_once(cyc, to);
    n_cmp++;
    if (got_prod(0) !== 32'h40000000) begin
      n_bad++;
      $display("FAIL corner_min_min got %h want 40000000", got_prod(0));
    end
    n_cmp++;
    if (got_prod(1) !== 32'hFFFF8000) begin
      n_bad++;
      $display("FAIL corner_min_one got %h want ffff8000", got_prod(1));
    end
    n_cmp++;
    if (got_prod(2) !== 32'hC0008000) begin
      n_bad++;
      $display("FAIL corner_max_min got %h want c0008000", got_prod(2));
    end
  endtask

  task automatic test_random();
    int cyc;
    bit to;
    bit src_ok;
    for (int r = 0; r < 10; r++) begin
      load_random();
      run_once(cyc, to);
      n_cmp++;
      if (to || cyc != RUN_CYC) begin
        n_bad++;
        $display("FAIL rand%0d_latency got %0d (timeout=%0b) want %0d", r, cyc, to, RUN_CYC);
      end
      for (int j = 0; j < 16; j++) begin
        n_cmp++;
        if (got_prod(j) !== ref_prod(j)) begin
          n_bad++;
          $display("FAIL rand%0d_prod[%0d] got %h want %h", r, j, got_prod(j), ref_prod(j));
        end
      end
      src_ok = 1'b1;
      for (int i = 0; i < 64; i++) if (mem[i] !== src[i]) src_ok = 1'b0;
      n_cmp++;
      if (!src_ok) begin
        n_bad++;
        $display("FAIL rand%0d_src_intact got modified source want untouched", r);
      end
      start = 1'b1; tick();
      n_cmp++;
      if (done !== 1'b0) begin
        n_bad++;
        $display("FAIL rand%0d_done_start_high got %b want 0", r, done);
      end
    end
  endtask

  task automatic test_abort();
    int cyc;
    bit to;
    bit dst_ok;
    logic [31:0] p0;
    load_random();
    p0 = ref_prod(0);
    start = 1'b1; tick(); start = 1'b0; tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_wr_busy got %b want 1", busy);
    end
    repeat (WR_ABORT_CYC) tick();
    start = 1'b1; #1;
    n_cmp++;
    if (mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_wr_we got %b want 0", mem_we);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_wr_idle got busy=%b done=%b want 0 0", busy, done);
    end
    n_cmp++;
    if (mem[64] !== p0[31:24] || mem[65] !== 8'hAA) begin
      n_bad++;
      $display("FAIL abort_wr_bytes got %h %h want %h aa", mem[64], mem[65], p0[31:24]);
    end

    load_random();
    start = 1'b0; tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_rd_busy got %b want 1", busy);
    end
    repeat (ABORT_CYC) tick();
    start = 1'b1; #1;
    n_cmp++;
    if (mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_rd_we got %b want 0", mem_we);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_rd_idle got busy=%b done=%b want 0 0", busy, done);
    end
    for (int j = 0; j < 2; j++) begin
      n_cmp++;
      if (got_prod(j) !== ref_prod(j)) begin
        n_bad++;
        $display("FAIL abort_kept[%0d] got %h want %h", j, got_prod(j), ref_prod(j));
      end
    end
    dst_ok = 1'b1;
    for (int i = 72; i < 128; i++) if (mem[i] !== 8'hAA) dst_ok = 1'b0;
    n_cmp++;
    if (!dst_ok) begin
      n_bad++;
      $display("FAIL abort_untouched got written bytes in [72:127] want all aa");
    end
    run_once(cyc, to);
    n_cmp++;
    if (to || cyc != RUN_CYC) begin
      n_bad++;
      $display("FAIL abort_rerun_latency got %0d (timeout=%0b) want %0d", cyc, to, RUN_CYC);
    end
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if (got_prod(j) !== ref_prod(j)) begin
        n_bad++;
        $display("FAIL abort_rerun_prod[%0d] got %h want %h", j, got_prod(j), ref_prod(j));
      end
    end
  endtask

  task automatic test_reset_mid_wr();
    int cyc;
    bit to;
    bit quiet;
    load_random();
    start = 1'b1; tick(); start = 1'b0; tick();
    repeat (RST_CYC) tick();
    n_cmp++;
    if (mem_we !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre_we got %b want 1", mem_we);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    n_cmp++;
    if ({busy, done, mem_we, mem_addr, mem_wdata} !== 19'd0) begin
      n_bad++;
      $display("FAIL rst_mid_wr got busy=%b done=%b we=%b addr=%h wdata=%h want all 0",
               busy, done, mem_we, mem_addr, mem_wdata);
    end
    quiet = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (mem_we !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    n_cmp++;
    if (!quiet) begin
      n_bad++;
      $display("FAIL rst_quiet got activity after reset want none");
    end
    load_random();
    run_once(cyc, to);
    n_cmp++;
    if (to || cyc != RUN_CYC) begin
      n_bad++;
      $display("FAIL rst_rerun_latency got %0d (timeout=%0b) want %0d", cyc, to, RUN_CYC);
    end
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if (got_prod(j) !== ref_prod(j)) begin
        n_bad++;
        $display("FAIL rst_rerun_prod[%0d] got %h want %h", j, got_prod(j), ref_prod(j));
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_corner();
    test_random();
    test_abort();
    test_reset_mid_wr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
